// File: rtl/led7seg_capture_if.sv
// Bus bundle for led7seg_capture: the sampled 7-segment/anode inputs plus the decoded outputs.
// LED7SEG_CAPTURE_RAW_EN adds the raw_seg output carrying the normalised segment byte per digit.
interface led7seg_capture_if #(
    parameter int NDIG = 8
);
    logic [7:0]        led;
    logic [7:0]        sa;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   valid;
    logic              upd;
    logic [2:0]        upd_idx;
    logic              frame_done;
`ifdef LED7SEG_CAPTURE_RAW_EN
    logic [8*NDIG-1:0] raw_seg;

    modport master (output led, sa,
                    input  digits, dp, valid, upd, upd_idx, frame_done, raw_seg);
    modport slave  (input  led, sa,
                    output digits, dp, valid, upd, upd_idx, frame_done, raw_seg);
`else
    modport master (output led, sa,
                    input  digits, dp, valid, upd, upd_idx, frame_done);
    modport slave  (input  led, sa,
                    output digits, dp, valid, upd, upd_idx, frame_done);
`endif
endinterface

// File: rtl/led7seg_capture.sv
// Decodes a multiplexed 7-segment bus back into per-digit hex registers and flags full scan frames.
// Optional macro LED7SEG_CAPTURE_RAW_EN keeps the normalised segment byte of each capture in raw_seg.
module led7seg_capture #(
    parameter int NDIG        = 8,
    parameter int STABLE_CYC  = 4,
    parameter int SEG_ACT_LOW = 1,
    parameter int SA_ACT_LOW  = 1
) (
    input logic               clk,
    input logic               rst,
    led7seg_capture_if.slave  bus
);
    localparam logic [7:0] SA_IDLE = (SA_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYC);

    logic [7:0]        led_r, sa_r, led_n, sa_n;
    logic [7:0]        prev_led;
    logic [2:0]        prev_idx, sel_idx;
    logic [3:0]        sel_cnt;
    logic              sel_ok;
    logic [7:0]        run, run_nxt;
    logic              cap;
    logic [4:0]        dec;
    logic [NDIG-1:0]   seen, seen_set;
    logic              all_seen;

    logic [4*NDIG-1:0] digits_q;
    logic [NDIG-1:0]   dp_q, valid_q;
    logic              upd_q, frame_q;
    logic [2:0]        upd_idx_q;

    function automatic logic [4:0] dec7(input logic [6:0] s);
        case (s)
            7'h3F: dec7 = 5'h10;  7'h06: dec7 = 5'h11;
            7'h5B: dec7 = 5'h12;  7'h4F: dec7 = 5'h13;
            7'h66: dec7 = 5'h14;  7'h6D: dec7 = 5'h15;
            7'h7D: dec7 = 5'h16;  7'h07: dec7 = 5'h17;
            7'h7F: dec7 = 5'h18;  7'h6F: dec7 = 5'h19;
            7'h77: dec7 = 5'h1A;  7'h7C: dec7 = 5'h1B;
            7'h39: dec7 = 5'h1C;  7'h5E: dec7 = 5'h1D;
            7'h79: dec7 = 5'h1E;  7'h71: dec7 = 5'h1F;
            default: dec7 = 5'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            led_r <= 8'h00;
            sa_r  <= SA_IDLE;
        end else begin
            led_r <= bus.led;
            sa_r  <= bus.sa;
        end
    end

    assign led_n = (SEG_ACT_LOW != 0) ? ~led_r : led_r;
    assign sa_n  = (SA_ACT_LOW != 0)  ? ~sa_r  : sa_r;

    always_comb begin
        sel_idx = 3'd0;
        sel_cnt = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (sa_n[i]) begin
                sel_cnt = sel_cnt + 4'd1;
                sel_idx = 3'(i);
            end
        end
        sel_ok = (sel_cnt == 4'd1);
    end

    // A run of 0 means "no reference sample", so the first legal sample after a gap always loads 1.
    always_comb begin
        if (!sel_ok)
            run_nxt = 8'd0;
        else if (run != 8'd0 && sel_idx == prev_idx && led_n == prev_led)
            run_nxt = (run == RUN_MAX) ? run : run + 8'd1;
        else
            run_nxt = 8'd1;
    end

    assign cap      = sel_ok && (run_nxt == RUN_MAX) && (run != RUN_MAX);
    assign dec      = dec7(led_n[6:0]);
    assign seen_set = seen | (NDIG'(1) << sel_idx);
    assign all_seen = &seen_set;

    // upd is a one-cycle strobe with no back-pressure: digits/dp/valid/upd_idx are already
    // updated while upd is high, and frame_done can only be high together with upd.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_led  <= 8'h00;
            prev_idx  <= 3'd0;
            run       <= 8'd0;
            seen      <= '0;
            digits_q  <= '0;
            dp_q      <= '0;
            valid_q   <= '0;
            upd_q     <= 1'b0;
            frame_q   <= 1'b0;
            upd_idx_q <= 3'd0;
        end else begin
            prev_led <= led_n;
            prev_idx <= sel_idx;
            run      <= run_nxt;
            upd_q    <= cap;
            frame_q  <= cap && all_seen;
            if (cap) begin
                upd_idx_q                  <= sel_idx;
                digits_q[4*sel_idx +: 4]   <= dec[3:0];
                valid_q[sel_idx]           <= dec[4];
                dp_q[sel_idx]              <= led_n[7];
                seen                       <= all_seen ? '0 : seen_set;
            end
        end
    end

`ifdef LED7SEG_CAPTURE_RAW_EN
    logic [8*NDIG-1:0] raw_q;

    always_ff @(posedge clk) begin
        if (rst)
            raw_q <= '0;
        else if (cap)
            raw_q[8*sel_idx +: 8] <= led_n;
    end

    assign bus.raw_seg = raw_q;
`endif

    assign bus.digits     = digits_q;
    assign bus.dp         = dp_q;
    assign bus.valid      = valid_q;
    assign bus.upd        = upd_q;
    assign bus.upd_idx    = upd_idx_q;
    assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_led7seg_capture.sv
// Directed bench for led7seg_capture: stimulus pushes expected captures, a negedge monitor checks them.
module tb_led7seg_capture;
    localparam int W = 26;   // {cycle[15:0], idx[2:0], value[3:0], dp, valid, frame_done}

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    logic [2:0]   ei;
    logic [6:0]   seg_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led7seg_capture_if #(.NDIG(8)) bus ();

    led7seg_capture #(.NDIG(8), .STABLE_CYC(4), .SEG_ACT_LOW(1), .SA_ACT_LOW(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // sel and seg are given active-high; the bus is driven active-low.
    task automatic hold(input logic [7:0] sel, input logic [7:0] seg, input int n);
        bus.sa  = ~sel;
        bus.led = ~seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cap_digit(input int idx, input logic [7:0] seg, input logic [3:0] val,
                             input logic vld, input logic fd, input int n);
        logic [15:0] c;
        c = 16'(cyc + 5);
        exp_q.push_back({c, 3'(idx), val, seg[7], vld, fd});
        hold(8'(1 << idx), seg, n);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_digits"}, bus.digits, 32'h0);
        chk({tag, "_dp"}, 32'(bus.dp), 32'h0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'h0);
        chk({tag, "_upd"}, 32'(bus.upd), 32'h0);
        chk({tag, "_upd_idx"}, 32'(bus.upd_idx), 32'h0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'h0);
    endtask

    always @(negedge clk) begin
        if (bus.upd) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_upd: upd with idx %0d at cycle %0d, required none",
                         bus.upd_idx, cyc);
            end else begin
                e  = exp_q.pop_front();
                ei = e[9:7];
                chk("upd_cycle", 32'(16'(cyc)), 32'(e[25:10]));
                chk("upd_idx", 32'(bus.upd_idx), 32'(ei));
                chk("digit_value", 32'(bus.digits[4*ei +: 4]), 32'(e[6:3]));
                chk("digit_dp", 32'(bus.dp[ei]), 32'(e[2]));
                chk("digit_valid", 32'(bus.valid[ei]), 32'(e[1]));
                chk("frame_done", 32'(bus.frame_done), 32'(e[0]));
            end
        end else if (bus.frame_done) begin
            checks++;
            errors++;
            $display("FAIL stray_frame_done: frame_done=1 without upd at cycle %0d, required 0", cyc);
        end
    end

    initial begin
        rst     = 1'b1;
        bus.sa  = 8'hFF;
        bus.led = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // Single digit 0 showing "1"
        cap_digit(0, 8'h06, 4'h1, 1'b1, 1'b0, 6);
        chk("t1_digit0", 32'(bus.digits[3:0]), 32'h1);
        chk("t1_valid", 32'(bus.valid), 32'h01);
        chk("t1_dp", 32'(bus.dp), 32'h00);

        // Patterns held one cycle short of the threshold never capture
        hold(8'h02, 8'h5B, 3);
        hold(8'h02, 8'h4F, 3);
        hold(8'h00, 8'h00, 6);
        chk("t2_digits", bus.digits, 32'h00000001);
        chk("t2_valid", 32'(bus.valid), 32'h01);

        // Two full scans, one frame_done each
        for (int i = 0; i < 8; i++)
            cap_digit(i, {1'b0, seg_tab[i]}, 4'(i), 1'b1, i == 7, 5);
        chk("t3_digits", bus.digits, 32'h76543210);
        chk("t3_valid", 32'(bus.valid), 32'hFF);
        for (int i = 0; i < 8; i++)
            cap_digit(i, {1'b0, seg_tab[i+8]}, 4'(i + 8), 1'b1, i == 7, 5);
        chk("t3_digits2", bus.digits, 32'hFEDCBA98);
        chk("t3_dp2", 32'(bus.dp), 32'h00);

        // Long hold captures once; ghosting and blanking restart the run
        cap_digit(2, {1'b0, seg_tab[5]}, 4'h5, 1'b1, 1'b0, 12);
        hold(8'h03, {1'b0, seg_tab[5]}, 10);
        hold(8'h00, {1'b0, seg_tab[5]}, 10);
        cap_digit(2, {1'b0, seg_tab[5]}, 4'h5, 1'b1, 1'b0, 5);
        chk("t4_digits", bus.digits, 32'hFEDCB598);

        // Decimal point only: invalid pattern, value 0, dp kept
        cap_digit(3, 8'h80, 4'h0, 1'b0, 1'b0, 5);
        chk("t5_valid", 32'(bus.valid), 32'hF7);
        chk("t5_digit3", 32'(bus.digits[15:12]), 32'h0);
        chk("t5_dp", 32'(bus.dp), 32'h08);

        // Reset mid-scan clears outputs and the seen mask
        for (int i = 0; i < 4; i++)
            cap_digit(i, {1'b0, seg_tab[i+1]}, 4'(i + 1), 1'b1, 1'b0, 5);
        rst    = 1'b1;
        bus.sa = 8'hFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("midrst");
        for (int i = 4; i < 8; i++)
            cap_digit(i, {1'b0, seg_tab[i]}, 4'(i), 1'b1, 1'b0, 5);
        for (int i = 0; i < 4; i++)
            cap_digit(i, {1'b0, seg_tab[i]}, 4'(i), 1'b1, i == 3, 5);
        chk("t6_digits", bus.digits, 32'h76543210);
        chk("t6_valid", 32'(bus.valid), 32'hFF);

        hold(8'h00, 8'h00, 10);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led7seg_capture.md
Name: led7seg_capture

Overview:
- Receive-side counterpart of the led7seg driver.
- Samples a multiplexed 7-segment bus (8-bit segment vector plus 8-bit anode select), waits for each digit's pattern to be stable, decodes the pattern back to a hex value and stores it in per-digit registers.
- Flags complete scan frames.
- Sits in benches and self-check logic as a display monitor or scoreboard front end.

Parameters:
- NDIG, 8: number of digit positions decoded, 1..8; uses sa[NDIG-1:0].
- STABLE_CYC, 4: identical consecutive samples required before capture, 2..255.
- SEG_ACT_LOW, 1: 1 means led[] is active-low (common anode); 0 means active-high.
- SA_ACT_LOW, 1: 1 means sa[] is active-low; 0 means active-high.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- led  in  8  segments; bit0=a ... bit6=g, bit7=dp.
- sa  in  8  anode/digit select, one-hot when driving.
- digits  out  4*NDIG  decoded hex values; digit i at [4i+3:4i].
- dp  out  NDIG  captured decimal point per digit.
- valid  out  NDIG  1 means the last capture for digit i matched the hex table.
- upd  out  1  one-cycle pulse, capture occurred.
- upd_idx  out  3  digit index of the current upd.
- frame_done  out  1  one-cycle pulse, every digit captured since the last frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On rst all outputs are 0, internal input register cleared to "no select", run counter 0, seen mask 0. Reset mid-run discards the partial run and the seen mask.
- Input stage: led and sa are registered once, then normalised to active-high via the parameters.
- Select decode: the select is legal only when exactly one of sa[NDIG-1:0] is active.
  - Zero or multiple active (ghosting or blanking gap): run counter forced to 0, no capture.
- Run counter:
  - Increments (saturating at STABLE_CYC) while the registered (index, led[7:0]) equals the previous registered value.
  - Reloads to 1 on any change with a legal select.
- Capture: happens on the edge where the run counter reaches exactly STABLE_CYC; at most once per run.
  - A held pattern never recaptures.
  - The same digit re-captures only after an intervening change.
- Latency: a pattern applied before edge E and held produces updated digits/dp/valid after edge E+STABLE_CYC. upd is high during the following cycle, together with upd_idx.
- Decode table (active-high led[6:0] to value):
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - Any other pattern, including blank 00, sets valid[i]=0 and digits[i]=0.
  - dp[i] always takes led[7], whether or not the pattern is valid.
- Seen mask: each capture sets seen[idx].
  - When a capture makes seen all-ones over NDIG, frame_done pulses on the same cycle as upd and seen clears to 0 on that edge.
  - With NDIG=1 every capture pulses frame_done.
- Unselected digits hold their last captured value indefinitely.

Optional Feature:
- Macro: LED7SEG_CAPTURE_RAW_EN.
- Defined: adds output raw_seg [8*NDIG-1:0], holding the normalised led[7:0] of the last capture per digit, written on the same edge as digits. Reset value 0.
- Undefined: port and storage are absent; all other behaviour is identical.

Test Plan:
- Reset, then hold sa=FE (digit 0, active-low) and led=~8'h06 for 6 cycles -> digits[3:0]=1, valid[0]=1, dp[0]=0. Exactly one upd pulse with upd_idx=0, 4 edges after the first sampled edge.
- Hold a pattern for only STABLE_CYC-1 cycles, then change it -> no upd, outputs unchanged.
- Scan digits 0..7 with values 0..7, each held 5 cycles -> digits=32'h76543210, valid=FF. frame_done pulses once, coincident with the upd for idx 7. A second full scan gives a second frame_done.
- sa=FC (two selects) held 10 cycles, then sa=FF (no select) held 10 cycles -> no upd; run counter restarts on return to one-hot.
- led=~8'h80 (dp only) on digit 3 -> valid[3]=0, digits[15:12]=0, dp[3]=1.
- Assert rst for 1 cycle mid-scan after 4 digits captured -> all outputs 0. Completing the remaining 4 digits gives no frame_done; a full 8-digit scan is required.
